// File: rtl/regfile_scb.sv
// Integer register file: two combinational read ports with write-through bypass, one write
// port, a per-register pending scoreboard, and a post-reset sequencer that zeroes storage.
module regfile_scb #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            init_busy,
   input  logic [AW-1:0]   rR1,
   input  logic [AW-1:0]   rR2,
   output logic [XLEN-1:0] rD1,
   output logic [XLEN-1:0] rD2,
   output logic            pend1,
   output logic            pend2,
   input  logic [AW-1:0]   wR,
   input  logic [XLEN-1:0] wD,
   input  logic            rf_we,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd
);

   localparam int unsigned NREG = 2 ** AW;

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic              busy_q, busy_d;
   logic [NREG-1:0]   pend_q, pend_d;

   // Entry 0 is never written and never read (reads of x0 are forced to zero).
   logic [XLEN-1:0]   mem [NREG];

   logic              mem_we;
   logic [AW-1:0]     mem_wa;
   logic [XLEN-1:0]   mem_wd;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      pend_d  = pend_q;
      mem_we  = 1'b0;
      mem_wa  = wR;
      mem_wd  = wD;
      unique case (state_q)
         StInit: begin
            mem_we = 1'b1;
            mem_wa = idx_q;
            mem_wd = '0;
            idx_d  = idx_q + AW'(1);
            if (idx_q == AW'(NREG - 1)) begin
               state_d = StRun;
               busy_d  = 1'b0;
            end
         end
         StRun: begin
            if (rf_we && (wR != '0)) begin
               mem_we     = 1'b1;
               pend_d[wR] = 1'b0;
            end
            // Set after clear: a newer producer issued this cycle stays outstanding.
            if (iss_valid && (iss_rd != '0)) begin
               pend_d[iss_rd] = 1'b1;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StInit;
         idx_q   <= AW'(1);
         busy_q  <= 1'b1;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   assign init_busy = busy_q;

   always_comb begin
      rD1   = '0;
      pend1 = 1'b0;
      if ((state_q == StRun) && (rR1 != '0)) begin
         if (rf_we && (wR == rR1)) begin
            rD1 = wD;
         end else begin
            rD1   = mem[rR1];
            pend1 = pend_q[rR1];
         end
      end
   end

   always_comb begin
      rD2   = '0;
      pend2 = 1'b0;
      if ((state_q == StRun) && (rR2 != '0)) begin
         if (rf_we && (wR == rR2)) begin
            rD2 = wD;
         end else begin
            rD2   = mem[rR2];
            pend2 = pend_q[rR2];
         end
      end
   end

endmodule

// File: tb/tb_regfile_scb.sv
// Directed bench for regfile_scb: init sequencer, read/write, bypass, scoreboard, reset.
module tb_regfile_scb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            init_busy;
   logic [AW-1:0]   rR1, rR2, wR, iss_rd;
   logic [XLEN-1:0] rD1, rD2, wD;
   logic            pend1, pend2, rf_we, iss_valid;

   int total = 0;
   int bad   = 0;

   regfile_scb #(.XLEN(XLEN), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_busy (init_busy),
      .rR1       (rR1),
      .rR2       (rR2),
      .rD1       (rD1),
      .rD2       (rD2),
      .pend1     (pend1),
      .pend2     (pend2),
      .wR        (wR),
      .wD        (wD),
      .rf_we     (rf_we),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rf_we     = 1'b0;
      iss_valid = 1'b0;
      wR        = '0;
      wD        = '0;
      iss_rd    = '0;
   endtask

   // Counts cycles with init_busy high, starting #1 after the reset edge.
   task automatic count_busy(output int n);
      n = 0;
      while (init_busy === 1'b1 && n < 100) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      idle_inputs();
      rR1 = 5'd7;
      rR2 = 5'd5;
      step();
      step();
      total++;
      if (init_busy !== 1'b1) begin
         bad++; $display("FAIL reset_busy got=%b want=1", init_busy);
      end
      total++;
      if (rD1 !== '0 || pend1 !== 1'b0) begin
         bad++; $display("FAIL reset_rd1 got=%h/%b want=0/0", rD1, pend1);
      end
      rst_n = 1'b1;
      // Write and issue attempted during INIT must be lost.
      rf_we = 1'b1; wR = 5'd5; wD = 32'hDEADBEEF;
      iss_valid = 1'b1; iss_rd = 5'd6;
      #1;
      total++;
      if (rD2 !== '0 || pend2 !== 1'b0) begin
         bad++; $display("FAIL init_read got=%h/%b want=0/0", rD2, pend2);
      end
      #1;
      count_busy(n);
      idle_inputs();
      total++;
      if (n != 31) begin
         bad++; $display("FAIL init_busy_cycles got=%0d want=31", n);
      end
   endtask

   task automatic test_cleared();
      int nz;
      nz = 0;
      for (int i = 1; i < 32; i++) begin
         rR1 = AW'(i);
         #1;
         if (rD1 !== '0 || pend1 !== 1'b0) nz++;
      end
      total++;
      if (nz != 0) begin
         bad++; $display("FAIL init_clear nonzero_regs got=%0d want=0", nz);
      end
      rR1 = 5'd5;
      #1;
      total++;
      if (rD1 !== '0) begin
         bad++; $display("FAIL init_write_lost got=%h want=00000000", rD1);
      end
      rR1 = 5'd6;
      #1;
      total++;
      if (pend1 !== 1'b0) begin
         bad++; $display("FAIL init_issue_lost got=%b want=0", pend1);
      end
   endtask

   task automatic test_write_read();
      rf_we = 1'b1; wR = 5'd7; wD = 32'h12345678;
      step();
      wR = 5'd0; wD = 32'hFFFFFFFF;
      step();
      idle_inputs();
      rR1 = 5'd7; rR2 = 5'd0;
      #1;
      total++;
      if (rD1 !== 32'h12345678) begin
         bad++; $display("FAIL write_r7 got=%h want=12345678", rD1);
      end
      total++;
      if (rD2 !== 32'h0 || pend2 !== 1'b0) begin
         bad++; $display("FAIL read_x0 got=%h/%b want=0/0", rD2, pend2);
      end
   endtask

   task automatic test_bypass();
      rf_we = 1'b1; wR = 5'd9; wD = 32'hCAFEF00D; rR1 = 5'd9;
      #1;
      total++;
      if (rD1 !== 32'hCAFEF00D) begin
         bad++; $display("FAIL bypass_same_cycle got=%h want=cafef00d", rD1);
      end
      step();
      idle_inputs();
      #1;
      total++;
      if (rD1 !== 32'hCAFEF00D) begin
         bad++; $display("FAIL bypass_stored got=%h want=cafef00d", rD1);
      end
   endtask

   task automatic test_scoreboard();
      iss_valid = 1'b1; iss_rd = 5'd3;
      rR1 = 5'd3; rR2 = 5'd3;
      #1;
      total++;
      if (pend1 !== 1'b0) begin
         bad++; $display("FAIL pend_same_cycle got=%b want=0", pend1);
      end
      step();
      idle_inputs();
      #1;
      total++;
      if (pend1 !== 1'b1 || pend2 !== 1'b1) begin
         bad++; $display("FAIL pend_set got=%b%b want=11", pend1, pend2);
      end
      step();
      total++;
      if (pend1 !== 1'b1) begin
         bad++; $display("FAIL pend_hold got=%b want=1", pend1);
      end
      rf_we = 1'b1; wR = 5'd3; wD = 32'h33;
      #1;
      total++;
      if (pend1 !== 1'b0 || rD1 !== 32'h33) begin
         bad++; $display("FAIL pend_wb_cycle got=%b/%h want=0/00000033", pend1, rD1);
      end
      step();
      idle_inputs();
      #1;
      total++;
      if (pend1 !== 1'b0 || rD1 !== 32'h33) begin
         bad++; $display("FAIL pend_cleared got=%b/%h want=0/00000033", pend1, rD1);
      end
      iss_valid = 1'b1; iss_rd = 5'd0;
      step();
      idle_inputs();
      rR1 = 5'd0;
      #1;
      total++;
      if (pend1 !== 1'b0) begin
         bad++; $display("FAIL pend_x0 got=%b want=0", pend1);
      end
   endtask

   task automatic test_collision();
      iss_valid = 1'b1; iss_rd = 5'd4;
      step();
      iss_valid = 1'b1; iss_rd = 5'd4;
      rf_we = 1'b1; wR = 5'd4; wD = 32'h55; rR2 = 5'd4;
      #1;
      total++;
      if (pend2 !== 1'b0 || rD2 !== 32'h55) begin
         bad++; $display("FAIL collide_cycle got=%b/%h want=0/00000055", pend2, rD2);
      end
      step();
      idle_inputs();
      #1;
      total++;
      if (pend2 !== 1'b1 || rD2 !== 32'h55) begin
         bad++; $display("FAIL collide_after got=%b/%h want=1/00000055", pend2, rD2);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      rf_we = 1'b1; wR = 5'd10; wD = 32'hAA;
      iss_valid = 1'b1; iss_rd = 5'd10;
      step();
      idle_inputs();
      rR1 = 5'd10;
      #1;
      total++;
      if (pend1 !== 1'b1 || rD1 !== 32'hAA) begin
         bad++; $display("FAIL pre_reset got=%b/%h want=1/000000aa", pend1, rD1);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      count_busy(n);
      total++;
      if (n != 31) begin
         bad++; $display("FAIL reinit_cycles got=%0d want=31", n);
      end
      total++;
      if (rD1 !== '0 || pend1 !== 1'b0) begin
         bad++; $display("FAIL post_reset got=%h/%b want=0/0", rD1, pend1);
      end
   endtask

   initial begin
      rR1 = '0;
      rR2 = '0;
      test_reset();
      test_cleared();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_collision();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
